run_seq: RTL and testbench

Parametrised successor to run_mode, the programme sequencer of the washer controller. It steps through up to N_STG programme stages (wash/rinse/spin by default) selected by an enable mask. Each stage has its own duration in time units. Pause and clear come in as debounced levels from debouncer instances. Outputs are the one-hot current stage, remaining units, a busy/done status and a per-unit tick for the display and actuator logic.

---
 rtl/run_seq.sv | 184 ++++++++++++++++++
 tb/tb_run_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_seq.sv
// run_seq: washer programme sequencer stepping through enabled stages with per-stage unit durations.
// Optional beep output on DONE entry is built when RUN_SEQ_BEEP_EN is defined.
`timescale 1ns/1ps

module run_seq #(
    parameter int N_STG    = 3,
    parameter int UW       = 6,
    parameter int TIM_CMAX = 100000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_STG-1:0]      init,
    input  logic [N_STG*UW-1:0]   u_dur,
    input  logic                  pau,
    input  logic                  clr,
    output logic [N_STG-1:0]      stg,
    output logic [UW-1:0]         rem,
    output logic                  busy,
    output logic                  done,
    output logic                  tick
`ifdef RUN_SEQ_BEEP_EN
    ,
    output logic                  beep
`endif
);

    localparam int PW = (TIM_CMAX > 1) ? $clog2(TIM_CMAX) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TIM_CMAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic [PW-1:0]        presc, presc_nx;
    logic [N_STG-1:0]     mask_q, mask_nx;
    logic [N_STG*UW-1:0]  dur_q, dur_nx;
    logic [N_STG-1:0]     stg_nx;
    logic [UW-1:0]        rem_nx;
    logic [N_STG-1:0]     first_stg, next_stg;
    logic                 tick_c;

    function automatic logic [N_STG-1:0] eligible(input logic [N_STG-1:0] m,
                                                  input logic [N_STG*UW-1:0] d);
        logic [N_STG-1:0] e;
        e = '0;
        for (int i = 0; i < N_STG; i++)
            e[i] = m[i] && (d[i*UW +: UW] != '0);
        return e;
    endfunction

    function automatic logic [N_STG-1:0] lowest(input logic [N_STG-1:0] v);
        return v & (~v + N_STG'(1));
    endfunction

    function automatic logic [UW-1:0] dur_of(input logic [N_STG-1:0] oh,
                                             input logic [N_STG*UW-1:0] d);
        logic [UW-1:0] r;
        r = '0;
        for (int i = 0; i < N_STG; i++)
            if (oh[i]) r = r | d[i*UW +: UW];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= '0;
            mask_q <= '0;
            dur_q  <= '0;
            stg    <= '0;
            rem    <= '0;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            mask_q <= mask_nx;
            dur_q  <= dur_nx;
            stg    <= stg_nx;
            rem    <= rem_nx;
        end
    end

    // Stage hand-over happens on the tick edge itself, so the next stage starts with no dead cycle.
    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        mask_nx   = mask_q;
        dur_nx    = dur_q;
        stg_nx    = stg;
        rem_nx    = rem;
        tick_c    = 1'b0;
        first_stg = lowest(eligible(init, u_dur));
        next_stg  = lowest(eligible(mask_q, dur_q) & ~(stg | (stg - N_STG'(1))));

        if (clr) begin
            state_nx = IDLE;
            presc_nx = '0;
            stg_nx   = '0;
            rem_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    mask_nx  = init;
                    dur_nx   = u_dur;
                    presc_nx = '0;
                    if (first_stg != '0) begin
                        state_nx = RUN;
                        stg_nx   = first_stg;
                        rem_nx   = dur_of(first_stg, u_dur);
                    end else begin
                        state_nx = DONE;
                        stg_nx   = '0;
                        rem_nx   = '0;
                    end
                end
                RUN: begin
                    if (pau) begin
                        state_nx = PAUSE;
                    end else if (presc == P_LAST) begin
                        presc_nx = '0;
                        tick_c   = 1'b1;
                        if (rem > UW'(1)) begin
                            rem_nx = rem - UW'(1);
                        end else if (next_stg != '0) begin
                            stg_nx = next_stg;
                            rem_nx = dur_of(next_stg, dur_q);
                        end else begin
                            state_nx = DONE;
                            stg_nx   = '0;
                            rem_nx   = '0;
                        end
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!pau) state_nx = RUN;
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);
    assign tick = tick_c;

`ifdef RUN_SEQ_BEEP_EN
    localparam int BW = $clog2(3 * TIM_CMAX);
    localparam logic [BW-1:0] B_LAST = BW'(3 * TIM_CMAX - 1);

    logic [BW-1:0] beep_cnt;

    // Beep starts on the edge that enters DONE and runs for three time units.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (clr) begin
            beep     <= 1'b0;
            beep_cnt <= '0;
        end else if (state != DONE && state_nx == DONE) begin
            beep     <= 1'b1;
            beep_cnt <= '0;
        end else if (beep) begin
            if (beep_cnt == B_LAST) begin
                beep     <= 1'b0;
                beep_cnt <= '0;
            end else begin
                beep_cnt <= beep_cnt + BW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_run_seq.sv
// tb_run_seq: directed test of run_seq with TIM_CMAX=10, N_STG=3, UW=6.
// Define RUN_SEQ_BEEP_EN to also exercise the beep output.
`timescale 1ns/1ps

module tb_run_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  init;
    logic [17:0] u_dur;
    logic        pau;
    logic        clr;
    logic [2:0]  stg;
    logic [5:0]  rem;
    logic        busy;
    logic        done;
    logic        tick;
`ifdef RUN_SEQ_BEEP_EN
    logic        beep;
`endif

    int total = 0;
    int bad = 0;
    int tick_total = 0;
    int tick_snap;
    int n;

    run_seq #(.N_STG(3), .UW(6), .TIM_CMAX(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .u_dur (u_dur),
        .pau   (pau),
        .clr   (clr),
        .stg   (stg),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .tick  (tick)
`ifdef RUN_SEQ_BEEP_EN
        ,
        .beep  (beep)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tick === 1'b1) tick_total <= tick_total + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic p, input logic [2:0] m,
                                 input logic [5:0] d0, input logic [5:0] d1, input logic [5:0] d2);
        clr   = c;
        pau   = p;
        init  = m;
        u_dur = {d2, d1, d0};
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        #12;
        checkOutput("rst_stg", stg, 3'b000);
        checkOutput("rst_rem", rem, 6'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_tick", tick, 1'b0);
        rst_n = 1'b1;
        step(3);

        $display("[TB] basic run");
        applyStimulus(1'b0, 1'b0, 3'b111, 6'd2, 6'd3, 6'd1);
        tick_snap = tick_total;
        step(1);
        checkOutput("basic_s0_stg", stg, 3'b001);
        checkOutput("basic_s0_rem", rem, 6'd2);
        checkOutput("basic_s0_busy", busy, 1'b1);
        step(19);
        checkOutput("basic_s0_end_stg", stg, 3'b001);
        checkOutput("basic_s0_end_rem", rem, 6'd1);
        step(1);
        checkOutput("basic_s1_stg", stg, 3'b010);
        checkOutput("basic_s1_rem", rem, 6'd3);
        step(29);
        checkOutput("basic_s1_end_stg", stg, 3'b010);
        step(1);
        checkOutput("basic_s2_stg", stg, 3'b100);
        checkOutput("basic_s2_rem", rem, 6'd1);
        step(9);
        checkOutput("basic_s2_end_done", done, 1'b0);
        step(1);
        checkOutput("basic_done", done, 1'b1);
        checkOutput("basic_done_busy", busy, 1'b0);
        checkOutput("basic_done_stg", stg, 3'b000);
        checkOutput("basic_done_rem", rem, 6'd0);
        checkOutput("basic_ticks", tick_total - tick_snap, 6);
        applyStimulus(1'b0, 1'b1, 3'b000, 6'd0, 6'd0, 6'd0);
        step(5);
        checkOutput("basic_done_hold", done, 1'b1);
        checkOutput("basic_ticks_after", tick_total - tick_snap, 6);

        $display("[TB] mask and skip");
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(2);
        checkOutput("clr_to_idle_done", done, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b011, 6'd0, 6'd4, 6'd5);
        step(1);
        checkOutput("skip_stg", stg, 3'b010);
        checkOutput("skip_rem", rem, 6'd4);
        step(39);
        checkOutput("skip_end_stg", stg, 3'b010);
        step(1);
        checkOutput("skip_done", done, 1'b1);
        checkOutput("skip_done_stg", stg, 3'b000);
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(2);
        applyStimulus(1'b0, 1'b0, 3'b000, 6'd3, 6'd3, 6'd3);
        checkOutput("empty_busy_pre", busy, 1'b0);
        step(1);
        checkOutput("empty_done", done, 1'b1);
        checkOutput("empty_busy", busy, 1'b0);

        $display("[TB] pause");
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(2);
        applyStimulus(1'b0, 1'b0, 3'b111, 6'd3, 6'd3, 6'd3);
        step(1);
        step(24);
        applyStimulus(1'b0, 1'b1, 3'b000, 6'd0, 6'd0, 6'd0);
        tick_snap = tick_total;
        step(400);
        checkOutput("pause_mid_stg", stg, 3'b001);
        checkOutput("pause_mid_rem", rem, 6'd1);
        checkOutput("pause_mid_busy", busy, 1'b1);
        step(400);
        checkOutput("pause_ticks", tick_total - tick_snap, 0);
        checkOutput("pause_end_rem", rem, 6'd1);
        pau = 1'b0;
        n = 824;
        while (done !== 1'b1 && n < 2000) begin
            step(1);
            n++;
        end
        checkOutput("pause_done_time_ok", (n >= 890 && n <= 891), 1'b1);
        if (n < 890 || n > 891) $display("[TB] pause done reached after %0d cycles", n);

        $display("[TB] clear priority");
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(2);
        applyStimulus(1'b0, 1'b0, 3'b111, 6'd2, 6'd3, 6'd1);
        step(1);
        step(25);
        checkOutput("clrp_pre_stg", stg, 3'b010);
        applyStimulus(1'b1, 1'b1, 3'b111, 6'd2, 6'd3, 6'd1);
        step(1);
        checkOutput("clrp_stg", stg, 3'b000);
        checkOutput("clrp_rem", rem, 6'd0);
        checkOutput("clrp_busy", busy, 1'b0);
        checkOutput("clrp_done", done, 1'b0);
        step(3);
        checkOutput("clrp_hold_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b011, 6'd4, 6'd2, 6'd7);
        step(1);
        checkOutput("restart_stg", stg, 3'b001);
        checkOutput("restart_rem", rem, 6'd4);
        step(39);
        checkOutput("restart_s0_end", stg, 3'b001);
        step(1);
        checkOutput("restart_s1_stg", stg, 3'b010);
        checkOutput("restart_s1_rem", rem, 6'd2);

        $display("[TB] async reset");
        step(3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_stg", stg, 3'b000);
        checkOutput("arst_rem", rem, 6'd0);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_done", done, 1'b0);
        checkOutput("arst_tick", tick, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b111, 6'd2, 6'd2, 6'd2);
        #7;
        rst_n = 1'b1;
        step(5);
        checkOutput("arst_idle_busy", busy, 1'b0);
        checkOutput("arst_idle_done", done, 1'b0);
        checkOutput("arst_idle_stg", stg, 3'b000);

`ifdef RUN_SEQ_BEEP_EN
        $display("[TB] beep");
        checkOutput("beep_idle", beep, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(1);
        checkOutput("beep_start", beep, 1'b1);
        step(29);
        checkOutput("beep_last", beep, 1'b1);
        step(1);
        checkOutput("beep_off", beep, 1'b0);
        checkOutput("beep_off_done", done, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(2);
        applyStimulus(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0);
        step(1);
        checkOutput("beep2_start", beep, 1'b1);
        step(11);
        checkOutput("beep2_c12", beep, 1'b1);
        clr = 1'b1;
        step(1);
        checkOutput("beep2_clr", beep, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
